// File: rtl/beat_tempo_tracker_if.sv
// Handshake bundle between the beat detector, the tempo tracker and the ADSR pulse filter.
interface beat_tempo_tracker_if #(
    parameter int unsigned BITS    = 8,
    parameter int unsigned MAX_BPM = 200
);
    localparam int unsigned BPM_W = $clog2(MAX_BPM + 1);

    logic             beat_in;
    logic [BITS-1:0]  beat_level;
    logic [BPM_W-1:0] bpm_estimate;
    logic             bpm_valid;
    logic [BITS-1:0]  pulse_amplitude;
    logic             beat_accepted;
    logic             busy;

    modport master (
        output beat_in, beat_level,
        input  bpm_estimate, bpm_valid, pulse_amplitude, beat_accepted, busy
    );

    modport slave (
        input  beat_in, beat_level,
        output bpm_estimate, bpm_valid, pulse_amplitude, beat_accepted, busy
    );
endinterface

// File: rtl/beat_tempo_tracker.sv
// Onset strobes -> smoothed BPM estimate (60000/interval_ms, IIR) and decaying pulse amplitude.
// Define BEAT_TIMEOUT_CLEAR_EN to clear the estimate when the beat stream times out.
module beat_tempo_tracker #(
    parameter int unsigned TICK_DIV   = 50_000,
    parameter int unsigned MIN_BPM    = 40,
    parameter int unsigned MAX_BPM    = 200,
    parameter int unsigned BITS       = 8,
    parameter int unsigned AVG_SHIFT  = 2,
    parameter int unsigned DECAY_STEP = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    beat_tempo_tracker_if.slave  bus
);
    localparam int unsigned MAX_INT_MS = 60000 / MIN_BPM;
    localparam int unsigned MIN_INT_MS = 60000 / MAX_BPM;
    localparam int unsigned BPM_W      = $clog2(MAX_BPM + 1);
    localparam int unsigned TICK_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [15:0] DIVIDEND   = 16'd60000;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DIVIDE, S_UPDATE} state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick_cnt;
    logic [15:0]         ms_cnt;
    logic [15:0]         interval;
    logic [15:0]         quo;
    logic [15:0]         rem;
    logic [3:0]          step;
    logic [BPM_W-1:0]    bpm_est;
    logic                bpm_vld;
    logic [BITS-1:0]     amp;
    logic                acc;
    logic                busy_r;

    logic                tick;
    logic                in_window;
    logic                accept;
    logic [16:0]         rem_shift;
    logic [16:0]         rem_trial;
    logic [BPM_W-1:0]    q_clamped;
    logic signed [9:0]   diff;
    logic [BPM_W-1:0]    bpm_next;

    always_comb begin
        tick      = (tick_cnt == TICK_W'(TICK_DIV - 1));
        in_window = (ms_cnt >= 16'(MIN_INT_MS)) && (ms_cnt <= 16'(MAX_INT_MS));
        accept    = bus.beat_in && ((state == S_IDLE) || ((state == S_ARMED) && in_window));

        // Restoring step: quo holds the not-yet-consumed dividend bits on top, quotient bits enter at the bottom.
        rem_shift = {rem, quo[15]};
        rem_trial = rem_shift - {1'b0, interval};

        if (quo < 16'(MIN_BPM))
            q_clamped = BPM_W'(MIN_BPM);
        else if (quo > 16'(MAX_BPM))
            q_clamped = BPM_W'(MAX_BPM);
        else
            q_clamped = BPM_W'(quo);

        diff     = $signed(10'(q_clamped)) - $signed(10'(bpm_est));
        bpm_next = BPM_W'($signed(10'(bpm_est)) + (diff >>> AVG_SHIFT));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            ms_cnt   <= '0;
            interval <= '0;
            quo      <= '0;
            rem      <= '0;
            step     <= '0;
            bpm_est  <= '0;
            bpm_vld  <= 1'b0;
            amp      <= '0;
            acc      <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            acc      <= accept;

            if (accept)
                ms_cnt <= '0;
            else if (tick && (ms_cnt != '1))
                ms_cnt <= ms_cnt + 1'b1;

            if (accept)
                amp <= bus.beat_level;
            else if (tick)
                amp <= (amp > BITS'(DECAY_STEP)) ? amp - BITS'(DECAY_STEP) : '0;

            case (state)
                S_IDLE: begin
                    if (accept)
                        state <= S_ARMED;
                end
                S_ARMED: begin
                    if (accept) begin
                        interval <= ms_cnt;
                        quo      <= DIVIDEND;
                        rem      <= '0;
                        step     <= '0;
                        busy_r   <= 1'b1;
                        state    <= S_DIVIDE;
                    end else if (ms_cnt > 16'(MAX_INT_MS)) begin
                        state <= S_IDLE;
`ifdef BEAT_TIMEOUT_CLEAR_EN
                        bpm_est <= '0;
                        bpm_vld <= 1'b0;
`else
                        bpm_est <= bpm_est;
                        bpm_vld <= bpm_vld;
`endif
                    end
                end
                S_DIVIDE: begin
                    if (!rem_trial[16]) begin
                        rem <= rem_trial[15:0];
                        quo <= {quo[14:0], 1'b1};
                    end else begin
                        rem <= rem_shift[15:0];
                        quo <= {quo[14:0], 1'b0};
                    end
                    step <= step + 1'b1;
                    if (step == 4'd15)
                        state <= S_UPDATE;
                end
                S_UPDATE: begin
                    bpm_est <= bpm_vld ? bpm_next : q_clamped;
                    bpm_vld <= 1'b1;
                    busy_r  <= 1'b0;
                    state   <= S_ARMED;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.bpm_estimate    = bpm_est;
    assign bus.bpm_valid       = bpm_vld;
    assign bus.pulse_amplitude = amp;
    assign bus.beat_accepted   = acc;
    assign bus.busy            = busy_r;
endmodule

// File: tb/tb_beat_tempo_tracker.sv
// Directed bench for beat_tempo_tracker with TICK_DIV=10 (1 ms = 10 clk); expected BPMs go through a scoreboard queue.
module tb_beat_tempo_tracker;
    logic clk = 1'b0;
    logic reset;
    int   edge_cnt = 0;
    int   n_asserts = 0;
    int   n_fail = 0;
    int   prev_est = 0;
    int   sb[$];

    beat_tempo_tracker_if #(.BITS(8), .MAX_BPM(200)) bus ();

    beat_tempo_tracker #(
        .TICK_DIV(10), .MIN_BPM(40), .MAX_BPM(200), .BITS(8), .AVG_SHIFT(2), .DECAY_STEP(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic goto(input int e);
        while (edge_cnt < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raises beat_in so that it is sampled exactly at edge e.
    task automatic beat(input int e, input logic [7:0] lvl);
        goto(e - 1);
        bus.beat_in    = 1'b1;
        bus.beat_level = lvl;
        @(posedge clk);
        #1;
        bus.beat_in    = 1'b0;
        bus.beat_level = 8'd0;
    endtask

    task automatic expect_update(input int e0, input int exp_bpm);
        int got_edge;
        int expv;
        sb.push_back(exp_bpm);
        chk("accepted", 32'(bus.beat_accepted), 32'd1);
        chk("busy_start", 32'(bus.busy), 32'd1);
        goto(e0 + 16);
        chk("hold_before_update", 32'(bus.bpm_estimate), 32'(prev_est));
        got_edge = -1;
        for (int i = 0; i < 40 && got_edge < 0; i++) begin
            if (!bus.busy) got_edge = edge_cnt;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("update_latency", 32'(got_edge), 32'(e0 + 17));
        if (sb.size() == 0) begin
            n_asserts++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            expv = sb.pop_front();
            chk("bpm_estimate", 32'(bus.bpm_estimate), 32'(expv));
            chk("bpm_valid", 32'(bus.bpm_valid), 32'd1);
            prev_est = expv;
        end
    endtask

    initial begin
        int b, f, g, h, i_e, j;
        reset          = 1'b1;
        bus.beat_in    = 1'b0;
        bus.beat_level = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bpm", 32'(bus.bpm_estimate), 32'd0);
        chk("rst_valid", 32'(bus.bpm_valid), 32'd0);
        chk("rst_amp", 32'(bus.pulse_amplitude), 32'd0);
        chk("rst_acc", 32'(bus.beat_accepted), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset = 1'b0;
        b = edge_cnt + 1;

        // Arming beat: accepted, no divide, amplitude loaded.
        beat(b, 8'd200);
        chk("arm_acc", 32'(bus.beat_accepted), 32'd1);
        chk("arm_busy", 32'(bus.busy), 32'd0);
        chk("arm_valid", 32'(bus.bpm_valid), 32'd0);
        chk("arm_amp", 32'(bus.pulse_amplitude), 32'd200);
        goto(b + 1);
        chk("acc_pulse_end", 32'(bus.beat_accepted), 32'd0);
        goto(b + 499);
        chk("amp_50_ticks", 32'(bus.pulse_amplitude), 32'd150);

        // Refractory beat at 100 ms: dropped, amplitude keeps decaying.
        beat(b + 1000, 8'd50);
        chk("refr_acc", 32'(bus.beat_accepted), 32'd0);
        chk("refr_amp", 32'(bus.pulse_amplitude), 32'd100);

        beat(b + 5000, 8'd100);
        expect_update(b + 5000, 120);
        beat(b + 9000, 8'd80);
        expect_update(b + 9000, 127);
        beat(b + 12000, 8'd80);
        expect_update(b + 12000, 145);
        beat(b + 14990, 8'd60);
        chk("int299_acc", 32'(bus.beat_accepted), 32'd0);
        beat(b + 15000, 8'd60);
        expect_update(b + 15000, 158);
        f = b + 30000;
        beat(f, 8'd90);
        expect_update(f, 128);

        goto(f + 15000);
        chk("pre_timeout_valid", 32'(bus.bpm_valid), 32'd1);
        chk("pre_timeout_bpm", 32'(bus.bpm_estimate), 32'd128);
        goto(f + 15020);
`ifdef BEAT_TIMEOUT_CLEAR_EN
        chk("timeout_bpm", 32'(bus.bpm_estimate), 32'd0);
        chk("timeout_valid", 32'(bus.bpm_valid), 32'd0);
        prev_est = 0;
`else
        chk("timeout_bpm", 32'(bus.bpm_estimate), 32'd128);
        chk("timeout_valid", 32'(bus.bpm_valid), 32'd1);
`endif
        chk("timeout_busy", 32'(bus.busy), 32'd0);

        // After timeout the next beat only re-arms.
        g = f + 20000;
        beat(g, 8'd200);
        chk("rearm_acc", 32'(bus.beat_accepted), 32'd1);
        chk("rearm_busy", 32'(bus.busy), 32'd0);
        goto(g + 30);
        chk("rearm_bpm_hold", 32'(bus.bpm_estimate), 32'(prev_est));
        goto(g + 1500);
        chk("amp_150_ticks", 32'(bus.pulse_amplitude), 32'd50);
        goto(g + 2000);
        chk("amp_200_ticks", 32'(bus.pulse_amplitude), 32'd0);
        goto(g + 3000);
        chk("amp_floor", 32'(bus.pulse_amplitude), 32'd0);

        h = g + 5000;
        beat(h, 8'd10);
`ifdef BEAT_TIMEOUT_CLEAR_EN
        expect_update(h, 120);
`else
        expect_update(h, 126);
`endif

        // Reset during cycle 8 of the divide aborts without an update.
        i_e = h + 4000;
        beat(i_e, 8'd10);
        chk("abort_acc", 32'(bus.beat_accepted), 32'd1);
        goto(i_e + 7);
        chk("abort_busy_pre", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_bpm", 32'(bus.bpm_estimate), 32'd0);
        chk("abort_valid", 32'(bus.bpm_valid), 32'd0);
        chk("abort_amp", 32'(bus.pulse_amplitude), 32'd0);
        chk("abort_acc_low", 32'(bus.beat_accepted), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        goto(i_e + 60);
        chk("abort_no_update_bpm", 32'(bus.bpm_estimate), 32'd0);
        chk("abort_no_update_valid", 32'(bus.bpm_valid), 32'd0);

        j = edge_cnt + 5;
        beat(j, 8'd30);
        chk("post_reset_arm_acc", 32'(bus.beat_accepted), 32'd1);
        chk("post_reset_arm_amp", 32'(bus.pulse_amplitude), 32'd30);
        goto(j + 25);
        chk("post_reset_idle_busy", 32'(bus.busy), 32'd0);
        chk("post_reset_valid", 32'(bus.bpm_valid), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
